// File: rtl/display_tube.sv
// Memory-mapped 8-digit seven-segment driver; scans one active-low anode per slot with a blanking lead-in.
// Pins follow register writes one edge later; reads return registered data one edge later; bus never stalls.
module display_tube #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        displayCtrl,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [3:0]  address,
  input  logic [15:0] write_data_input,
  output logic [15:0] read_data_output,
  output logic [7:0]  digit_enable,
  output logic [7:0]  segment
);

  localparam logic [3:0] ADDR_DATA_LO = 4'h0;
  localparam logic [3:0] ADDR_DATA_HI = 4'h2;
  localparam logic [3:0] ADDR_CTRL    = 4'h4;

  logic [15:0] data_lo;
  logic [15:0] data_hi;
  logic [15:0] ctrl;
  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;

  logic        wr_en;
  logic        rd_en;
  logic [15:0] rd_mux;
  logic [31:0] digits;
  logic [3:0]  cur_nibble;
  logic        lit;
  logic [7:0]  nxt_digit_enable;
  logic [7:0]  nxt_segment;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign wr_en  = displayCtrl & write_enable;
  assign rd_en  = displayCtrl & read_enable;
  assign digits = {data_hi, data_lo};

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      ADDR_DATA_LO: rd_mux = data_lo;
      ADDR_DATA_HI: rd_mux = data_hi;
      ADDR_CTRL:    rd_mux = ctrl;
      default:      rd_mux = 16'h0000;
    endcase
  end

  // Blanking lead-in keeps the previous digit's segments from ghosting onto the new anode.
  always_comb begin
    cur_nibble       = digits[{digit_idx, 2'b00} +: 4];
    lit              = (scan_cnt >= BLANK_CYCLES) && ctrl[digit_idx];
    nxt_digit_enable = 8'hFF;
    nxt_segment      = 8'hFF;
    if (lit) begin
      nxt_digit_enable = ~(8'h01 << digit_idx);
      nxt_segment      = ~{ctrl[{1'b1, digit_idx}], hex7(cur_nibble)};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_lo <= 16'h0000;
      data_hi <= 16'h0000;
      ctrl    <= 16'h0000;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA_LO: data_lo <= write_data_input;
        ADDR_DATA_HI: data_hi <= write_data_input;
        ADDR_CTRL:    ctrl    <= write_data_input;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data_output <= 16'h0000;
    end else begin
      read_data_output <= rd_en ? rd_mux : 16'h0000;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= 16'd0;
      digit_idx <= 3'd0;
    end else if (scan_cnt == SCAN_DIV - 16'd1) begin
      scan_cnt  <= 16'd0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_enable <= 8'hFF;
      segment      <= 8'hFF;
    end else begin
      digit_enable <= nxt_digit_enable;
      segment      <= nxt_segment;
    end
  end

  a_single_anode: assert property (@(posedge clock) disable iff (!reset) $onehot0(~digit_enable));

endmodule

// File: tb/tb_display_tube.sv
// Directed bench for display_tube with a short scan (8 cycles/slot, 2 blank cycles).
module tb_display_tube;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        displayCtrl = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [3:0]  address = 4'h0;
  logic [15:0] write_data_input = 16'h0000;
  logic [15:0] read_data_output;
  logic [7:0]  digit_enable;
  logic [7:0]  segment;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  display_tube #(.SCAN_DIV(16'd8), .BLANK_CYCLES(16'd2)) dut (
    .clock            (clock),
    .reset            (reset),
    .displayCtrl      (displayCtrl),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .address          (address),
    .write_data_input (write_data_input),
    .read_data_output (read_data_output),
    .digit_enable     (digit_enable),
    .segment          (segment)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // cyc counts rising edges since the last reset release.
  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    displayCtrl  = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    reset        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    displayCtrl      = 1'b1;
    write_enable     = 1'b1;
    address          = a;
    write_data_input = d;
    tick();
    write_enable = 1'b0;
    displayCtrl  = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic cs, output logic [15:0] d);
    displayCtrl = cs;
    read_enable = 1'b1;
    address     = a;
    tick();
    d           = read_data_output;
    read_enable = 1'b0;
    displayCtrl = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    logic [3:0]  a;
    reset       = 1'b0;
    displayCtrl = 1'b1;
    read_enable = 1'b1;
    address     = 4'h4;
    repeat (3) tick();
    n_checks++;
    if ({digit_enable, segment} !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL reset_pins: got %h expected FFFF", {digit_enable, segment});
    end
    n_checks++;
    if (read_data_output !== 16'h0000) begin
      n_fails++;
      $display("FAIL reset_rdata: got %h expected 0000", read_data_output);
    end
    displayCtrl = 1'b0;
    read_enable = 1'b0;
    reset       = 1'b1;
    cyc         = 0;
    for (int k = 0; k < 3; k++) begin
      a = 4'(2 * k);
      bus_read(a, 1'b1, rd);
      n_checks++;
      if (rd !== 16'h0000) begin
        n_fails++;
        $display("FAIL reset_read_%h: got %h expected 0000", a, rd);
      end
    end
  endtask

  task automatic test_digit_scan();
    logic [15:0] exp_tab [8];
    logic [15:0] exp;
    int c;
    int i;
    exp_tab = '{16'hFE99, 16'hFDB0, 16'hFBA4, 16'hF7F9,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    do_reset();
    bus_write(4'h0, 16'h1234);
    bus_write(4'h4, 16'h000F);
    while (cyc < 70) begin
      tick();
      c   = (cyc - 1) % 8;
      i   = ((cyc - 1) / 8) % 8;
      exp = (c < 2) ? 16'hFFFF : exp_tab[i];
      n_checks++;
      if ({digit_enable, segment} !== exp) begin
        n_fails++;
        $display("FAIL scan_lo edge %0d digit %0d: got %h expected %h", cyc, i, {digit_enable, segment}, exp);
      end
    end
  endtask

  task automatic test_dp_wrap();
    logic [15:0] exp_tab [8];
    logic [15:0] exp;
    int c;
    int i;
    exp_tab = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'hEFA1, 16'hDFC6, 16'hBF83, 16'h7F08};
    do_reset();
    bus_write(4'h2, 16'hABCD);
    bus_write(4'h4, 16'h80F0);
    while (cyc < 134) begin
      tick();
      c   = (cyc - 1) % 8;
      i   = ((cyc - 1) / 8) % 8;
      exp = (c < 2) ? 16'hFFFF : exp_tab[i];
      n_checks++;
      if ({digit_enable, segment} !== exp) begin
        n_fails++;
        $display("FAIL scan_hi_dp edge %0d digit %0d: got %h expected %h", cyc, i, {digit_enable, segment}, exp);
      end
    end
  endtask

  task automatic test_readback();
    logic [15:0] rd;
    bus_write(4'h0, 16'h1234);
    n_checks++;
    if (read_data_output !== 16'h0000) begin
      n_fails++;
      $display("FAIL idle_rdata: got %h expected 0000", read_data_output);
    end
    bus_read(4'h0, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h1234) begin
      n_fails++;
      $display("FAIL read_lo: got %h expected 1234", rd);
    end
    bus_read(4'h2, 1'b1, rd);
    n_checks++;
    if (rd !== 16'hABCD) begin
      n_fails++;
      $display("FAIL read_hi: got %h expected ABCD", rd);
    end
    bus_read(4'h4, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h80F0) begin
      n_fails++;
      $display("FAIL read_ctrl: got %h expected 80F0", rd);
    end
    bus_read(4'h6, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h0000) begin
      n_fails++;
      $display("FAIL read_unmapped: got %h expected 0000", rd);
    end
    bus_read(4'h0, 1'b0, rd);
    n_checks++;
    if (rd !== 16'h0000) begin
      n_fails++;
      $display("FAIL read_no_cs: got %h expected 0000", rd);
    end
    displayCtrl      = 1'b0;
    write_enable     = 1'b1;
    address          = 4'h0;
    write_data_input = 16'hFFFF;
    tick();
    write_enable = 1'b0;
    bus_write(4'h6, 16'hFFFF);
    bus_read(4'h0, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h1234) begin
      n_fails++;
      $display("FAIL write_no_cs: got %h expected 1234", rd);
    end
    bus_read(4'h4, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h80F0) begin
      n_fails++;
      $display("FAIL write_unmapped: got %h expected 80F0", rd);
    end
    displayCtrl      = 1'b1;
    write_enable     = 1'b1;
    read_enable      = 1'b1;
    address          = 4'h0;
    write_data_input = 16'h5555;
    tick();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    displayCtrl  = 1'b0;
    n_checks++;
    if (read_data_output !== 16'h1234) begin
      n_fails++;
      $display("FAIL read_write_same_edge: got %h expected 1234", read_data_output);
    end
    bus_read(4'h0, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h5555) begin
      n_fails++;
      $display("FAIL read_after_rw: got %h expected 5555", rd);
    end
  endtask

  task automatic test_mid_slot_write();
    do_reset();
    bus_write(4'h0, 16'h1234);
    bus_write(4'h4, 16'h0001);
    tick();
    n_checks++;
    if ({digit_enable, segment} !== 16'hFE99) begin
      n_fails++;
      $display("FAIL midslot_before: got %h expected FE99", {digit_enable, segment});
    end
    bus_write(4'h0, 16'h0008);
    n_checks++;
    if ({digit_enable, segment} !== 16'hFE99) begin
      n_fails++;
      $display("FAIL midslot_write_edge: got %h expected FE99", {digit_enable, segment});
    end
    tick();
    n_checks++;
    if ({digit_enable, segment} !== 16'hFE80) begin
      n_fails++;
      $display("FAIL midslot_update: got %h expected FE80", {digit_enable, segment});
    end
    while (cyc < 8) tick();
    n_checks++;
    if ({digit_enable, segment} !== 16'hFE80) begin
      n_fails++;
      $display("FAIL midslot_slot_end: got %h expected FE80", {digit_enable, segment});
    end
    tick();
    n_checks++;
    if ({digit_enable, segment} !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL midslot_next_blank: got %h expected FFFF", {digit_enable, segment});
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [15:0] rd;
    logic [3:0]  a;
    do_reset();
    bus_write(4'h2, 16'h0050);
    bus_write(4'h4, 16'h00FF);
    while (cyc < 43) tick();
    bus_read(4'h4, 1'b1, rd);
    n_checks++;
    if (rd !== 16'h00FF || {digit_enable, segment} !== 16'hDF92) begin
      n_fails++;
      $display("FAIL digit5_lit: got rd=%h pins=%h expected rd=00FF pins=DF92", rd, {digit_enable, segment});
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({digit_enable, segment, read_data_output} !== 32'hFFFF_0000) begin
      n_fails++;
      $display("FAIL async_reset: got pins=%h rd=%h expected FFFF 0000", {digit_enable, segment}, read_data_output);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 3; k++) begin
      a = 4'(4 - 2 * k);
      bus_read(a, 1'b1, rd);
      n_checks++;
      if (rd !== 16'h0000) begin
        n_fails++;
        $display("FAIL post_reset_read_%h: got %h expected 0000", a, rd);
      end
    end
    bus_write(4'h4, 16'h00FF);
    n_checks++;
    if ({digit_enable, segment} !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL post_reset_blank: got %h expected FFFF", {digit_enable, segment});
    end
    tick();
    n_checks++;
    if ({digit_enable, segment} !== 16'hFEC0) begin
      n_fails++;
      $display("FAIL post_reset_digit0: got %h expected FEC0", {digit_enable, segment});
    end
  endtask

  initial begin
    test_reset();
    test_digit_scan();
    test_dp_wrap();
    test_readback();
    test_mid_slot_write();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
